mul16_seq: RTL
==============

Name: mul16_seq

Overview:
- Sequential 16x16 shift-and-add multiplier. Returns the low 16 bits of a*b (Hack-style wraparound arithmetic).
- It is the downstream consumer of the 16-bit ripple adder: each iteration's accumulate goes through one Add16 instance.
- It sits beside the ALU as a multi-cycle arithmetic unit and uses a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width. Only 16 is supported because the datapath adder is a fixed Add16.
- CNT_W, 5, iteration counter width. Must hold the value 16.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- start  input  1  request a multiply; accepted only in IDLE.
- a  input  16  multiplicand, sampled on the accepting edge.
- b  input  16  multiplier, sampled on the accepting edge.
- out  output  16  low 16 bits of a*b; registered.
- busy  output  1  high while iterating (BUSY state).
- done  output  1  one-cycle pulse; out is valid and stable from this cycle on.

Behaviour:
- Reset:
  - Applies at any rising edge where reset=1, including mid-multiply.
  - Sets state=IDLE, out=0, busy=0, done=0, acc=0, count=0, a_reg=0, b_reg=0.
  - Reset has priority over start.
- States: IDLE, BUSY, DONE, with 2-bit encoding IDLE=0, BUSY=1, DONE=2. Encoding 3 is illegal and goes to IDLE on the next edge.
- IDLE:
  - On an edge with start=1: a_reg<=a, b_reg<=b, acc<=0, count<=0, state<=BUSY.
  - With start=0: stay in IDLE; out holds its last result.
- BUSY, each edge:
  - If b_reg[0]=1: acc<=Add16(acc,a_reg); otherwise acc holds.
  - a_reg<=a_reg<<1, with a zero shifted in.
  - b_reg<=b_reg>>1, with a zero shifted in.
  - count<=count+1.
  - Carry out of bit 15 is discarded (mod 2^16).
- BUSY exit: on the edge where count==15 (the 16th iteration), out<=the post-add accumulator value, done<=1, state<=DONE.
- DONE: on the next edge, done<=0 and state<=IDLE. start is ignored in DONE; it is accepted on the following edge if still high.
- Handshake timing:
  - If start is accepted at edge E0, busy=1 in the cycles after E0 through E16.
  - done=1 for exactly the cycle after E16, where out is valid.
  - Back-to-back throughput: one result every 18 cycles, with start held high.
- Fixed-latency boundaries:
  - There is no early termination.
  - b=0 still takes 16 iterations.
  - a=0 yields 0.
- start in BUSY: ignored. Operands are not resampled and there is no abort.
- out stability: out changes only on reset and on the DONE-entry edge, never during BUSY. Consumers may read it at any time after done.
- Output derivation: busy and done are registered or decoded from state; neither may be a combinational function of start.

Decomposition:
- Shared include (alongside the gate library):
  - state codes MUL_IDLE, MUL_BUSY, MUL_DONE;
  - the ITERATIONS=16 constant.
- Sub-module: one instance of the existing Add16 for the accumulate path.
  - Add16 inputs are acc and a_reg.
  - The b_reg[0] select is done with Mux16 between acc and the Add16 output.
- Control (FSM plus counter) and the shift registers stay in mul16_seq. No further sub-modules are needed.

Test Plan:
- Reset/idle: reset=1 for 2 edges, then start=0 for 5 edges -> out=0x0000, busy=0, done=0 throughout.
- Basic product and timing: a=0x0003, b=0x0005, start pulsed 1 cycle -> busy=1 for 16 cycles; done=1 exactly 1 cycle, 16 edges after the accepting edge; out=0x000F, which holds after done falls.
- Wraparound vectors, one run each -> out must be:
  - 0xFFFF*0xFFFF = 0x0001
  - 0x1234*0x9876 = 0x43F8
  - 0xAAAA*0x5555 = 0x1C72
  - 0x0000*0xFFFF = 0x0000
- Start while busy: start=1 with a=0x0002, b=0x0003; during BUSY change a=0x00FF, b=0x00FF and keep start=1 -> first result out=0x0006. Start is not seen in DONE; the next job is accepted on the following IDLE edge and yields 0xFE01.
- Reset mid-operation: start 0x1234*0x9876, assert reset at iteration 8 -> next cycle out=0, busy=0, done=0, state IDLE. A new start 0x0007*0x0009 after reset yields out=0x003F with the full 16-cycle latency.

Source files
------------

// File: rtl/mul16_seq_pkg.sv
// Shared constants and state codes for the sequential 16x16 multiplier.
//   WIDTH      : operand/result width (fixed at 16, the adder is a fixed Add16)
//   CNT_W      : iteration counter width (must hold ITERATIONS)
//   ITERATIONS : number of shift-and-add steps per multiply
package mul16_seq_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned ITERATIONS = 16;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul16_seq_add16.sv
// 16-bit ripple-carry adder (Add16); carry out of bit 15 is discarded.
//   i_a, i_b : addends
//   o_sum    : (i_a + i_b) mod 2^16
module mul16_seq_add16
    import mul16_seq_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    logic [WIDTH-1:0] w_carry;

    assign w_carry[0] = 1'b0;

    // One full adder per bit; the top carry is never formed.
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_fa
        assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
        if (gi < int'(WIDTH) - 1) begin : g_carry
            assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) |
                                   (i_a[gi] & w_carry[gi]) |
                                   (i_b[gi] & w_carry[gi]);
        end
    end

endmodule

// File: rtl/mul16_seq.sv
// Sequential shift-and-add multiplier returning the low 16 bits of a*b.
//   clock : system clock, rising edge
//   reset : synchronous active-high reset
//   start : request a multiply (accepted in IDLE only)
//   a, b  : operands, sampled on the accepting edge
//   out   : registered low 16 bits of the product
//   busy  : high while iterating
//   done  : one-cycle pulse when out has just been updated
module mul16_seq
    import mul16_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    mul_state_e       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_acc_next;

    mul16_seq_add16 u_add16 (
        .i_a   (r_acc),
        .i_b   (r_a),
        .o_sum (w_sum)
    );

    // Mux16: accumulate only when the current multiplier bit is set.
    assign w_acc_next = r_b[0] ? w_sum : r_acc;

    // Control FSM, iteration counter and operand shift registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= MUL_IDLE;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_count <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    r_acc   <= w_acc_next;
                    r_a     <= {r_a[WIDTH-2:0], 1'b0};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(ITERATIONS - 1)) begin
                        r_out   <= w_acc_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= MUL_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= MUL_IDLE;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule
